// File: rtl/lct_tx.sv
// LCT transmit path: input stage, frame builder, 16-deep alignment buffer, bunch-crossing counter and test-pattern output.
// Define LCT_TX_PARITY_EN to drive tx_data[27] with even parity; otherwise the bit is tied to 0.
module lct_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        hv,
  input  logic [1:0]  hp,
  input  logic [6:0]  hnp,
  input  logic        hfap,
  input  logic        lv,
  input  logic [1:0]  lp,
  input  logic [6:0]  lnp,
  input  logic        lfap,
  input  logic [1:0]  shower_int,
  input  logic        bc0,
  input  logic        trig_stop,
  input  logic [3:0]  delay,
  input  logic [1:0]  tx_mode,
  output logic [27:0] tx_data,
  output logic [11:0] bxn,
  output logic        bxn_err
);

  localparam logic [11:0] BXN_LAST = 12'd3563;
  localparam logic [4:0]  FLUSH_LEN = 5'd16;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_WALK   = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  // input stage
  logic        h_v, l_v, h_fa, l_fa, trig_q;
  logic [1:0]  h_p, l_p, shower_q, mode_q;
  logic [6:0]  h_np, l_np;
  logic [3:0]  d_q;

  logic [26:0] mem [16];
  logic [3:0]  wp;
  logic [3:0]  rd_addr;
  logic [4:0]  flush_cnt;
  logic [10:0] best, second;
  logic [26:0] frame, rd_frame, tx_next;
  logic        par;

  // Slot selection runs on the raw valid bits; trig_stop only masks the valids afterwards.
  always_comb begin
    best   = {h_fa, h_np, h_p, h_v};
    second = {l_fa, l_np, l_p, l_v};
    if (!h_v && l_v) begin
      best   = {l_fa, l_np, l_p, l_v};
      second = '0;
    end else if (h_v && l_v && (h_np == l_np)) begin
      second = '0;
    end
    if (trig_q) begin
      best[0]   = 1'b0;
      second[0] = 1'b0;
    end
  end

  assign frame = {(bxn == 12'd0), bxn[1:0], shower_q, second, best};

  // With zero delay the frame being written this cycle is the one to send.
  assign rd_addr  = wp - d_q;
  assign rd_frame = (d_q == 4'd0) ? frame : mem[rd_addr];

  always_comb begin
    tx_next = '0;
    case (tx_mode)
      MODE_NORMAL: tx_next = (flush_cnt != 5'd0) ? 27'd0 : rd_frame;
      MODE_ZERO:   tx_next = '0;
      MODE_WALK:   tx_next = (mode_q != MODE_WALK) ? 27'd1 : {tx_data[25:0], tx_data[26]};
      MODE_COUNT:  tx_next = (mode_q != MODE_COUNT) ? 27'd0 : tx_data[26:0] + 27'd1;
      default:     tx_next = '0;
    endcase
  end

`ifdef LCT_TX_PARITY_EN
  assign par = ^tx_next;
`else
  assign par = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      h_v <= 1'b0; h_p <= '0; h_np <= '0; h_fa <= 1'b0;
      l_v <= 1'b0; l_p <= '0; l_np <= '0; l_fa <= 1'b0;
      shower_q  <= '0;
      trig_q    <= 1'b0;
      d_q       <= '0;
      mode_q    <= MODE_NORMAL;
      wp        <= '0;
      flush_cnt <= '0;
      tx_data   <= '0;
      bxn       <= '0;
      bxn_err   <= 1'b0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      h_v <= hv; h_p <= hp; h_np <= hnp; h_fa <= hfap;
      l_v <= lv; l_p <= lp; l_np <= lnp; l_fa <= lfap;
      shower_q <= shower_int;
      trig_q   <= trig_stop;
      d_q      <= delay;
      mode_q   <= tx_mode;
      mem[wp]  <= frame;
      wp       <= wp + 4'd1;
      // A new delay value restarts the flush window; old buffer contents are misaligned.
      if (delay != d_q)
        flush_cnt <= FLUSH_LEN;
      else if (flush_cnt != 5'd0)
        flush_cnt <= flush_cnt - 5'd1;
      tx_data <= {par, tx_next};
      if (bc0 || (bxn == BXN_LAST))
        bxn <= '0;
      else
        bxn <= bxn + 12'd1;
      if (bc0 && (bxn != BXN_LAST))
        bxn_err <= 1'b1;
    end
  end

endmodule

// File: doc/lct_tx.md
LCT_TX -- requirements
Module: lct_tx

Interface
REQ-001 clk  input  1  system clock, one LCT frame per rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 hv, hp, hnp, hfap  input  1/2/7/1  best LCT: valid, quality, key wire group, accelerator flag.
REQ-004 lv, lp, lnp, lfap  input  1/2/7/1  second LCT: same fields as best LCT.
REQ-005 shower_int  input  2  high-multiplicity shower code.
REQ-006 bc0  input  1  TTC bunch-crossing-zero strobe, one cycle wide.
REQ-007 trig_stop  input  1  when 1, suppresses LCT valid bits.
REQ-008 delay  input  4  output alignment delay in clk cycles, 0..15.
REQ-009 tx_mode  input  2  output source: 0 normal, 1 all-zero, 2 walking-one, 3 counter.
REQ-010 tx_data  output  28  transmit frame to TMB.
REQ-011 bxn  output  12  local bunch-crossing number.
REQ-012 bxn_err  output  1  sticky flag: bc0 arrived out of phase.

Function
REQ-013 Frame layout SHALL be:
- [10:0] best LCT {fa, wire[6:0], q[1:0], v}.
- [21:11] second LCT, same layout.
- [23:22] shower_int.
- [25:24] bxn[1:0].
- [26] bc0 marker.
- [27] parity.
REQ-014 All inputs SHALL be registered once before frame building (input stage).
REQ-015 If trig_stop=1 in the input stage, both valid bits SHALL be forced to 0; all other fields pass unchanged.
REQ-016 If lv=1 and hv=0, the second LCT SHALL move into the best slot and the second slot SHALL be all zero.
REQ-017 If both are valid and hnp==lnp, the second slot SHALL be zeroed (duplicate drop).
REQ-018 Built frames SHALL be written every cycle into a 16-entry circular buffer.
REQ-019 Normal-mode latency from input to tx_data SHALL be exactly 2+delay cycles.
REQ-020 The write pointer SHALL wrap from 15 to 0.
REQ-021 The read address SHALL be write pointer minus delay, modulo 16.
REQ-022 When delay changes value, tx_data SHALL be forced to zero for the next 16 cycles (flush counter).
REQ-023 A further delay change during a flush SHALL restart the flush counter at 16.
REQ-024 bxn SHALL increment every cycle and wrap from 3563 to 0.
REQ-025 When bc0=1, bxn SHALL be 0 on the next cycle.
REQ-026 bxn_err SHALL set if bc0=1 while bxn!=3563; it stays set until reset.
REQ-027 The frame bc0 marker SHALL be 1 when the frame's bxn equals 0.
REQ-028 tx_mode=1: tx_data[26:0]=0.
REQ-029 tx_mode=2: tx_data[26:0] SHALL be a one-hot bit starting at bit 0 on the first cycle in the mode, rotating left each cycle, wrapping 26->0.
REQ-030 tx_mode=3: tx_data[26:0] SHALL be a free-running 27-bit counter that starts at 0 on entry to the mode.
REQ-031 A tx_mode change SHALL take effect on tx_data on the next cycle.
REQ-032 Test modes SHALL bypass the flush counter.
REQ-033 The circular buffer SHALL keep being written in all modes.

Reset
REQ-034 While rst=1 on a clock edge, the following SHALL all be 0 on the next cycle: tx_data, bxn, bxn_err, the write pointer, all buffer entries, the flush counter, the walking-one/counter state, and the input registers.
REQ-035 Reset asserted mid-flush or mid-test-mode SHALL abort the operation; after release, operation resumes in normal flow with bxn counting from 0.

Configuration
REQ-036 With LCT_TX_PARITY_EN defined, tx_data[27] SHALL be the even parity of tx_data[26:0] in every mode, so that [27:0] always has an even number of ones.
REQ-037 Without LCT_TX_PARITY_EN, tx_data[27] SHALL be constant 0 and no parity logic SHALL be generated.

Verification
REQ-038 Latency check:
- Stimulus: reset, delay=0, tx_mode=0, hv=1, hp=3, hnp=0x2A, hfap=1 for one cycle.
- Required: tx_data[10:0]=0x557 exactly 2 cycles later.
- Repeat with delay=15: same value at 17 cycles.
REQ-039 Promotion and duplicate drop:
- Stimulus lv=1, lnp=5, hv=0 -> best slot wire 5, second slot 0.
- Stimulus hv=lv=1, hnp=lnp=9 -> second slot 0.
REQ-040 bxn sequence:
- Free-run from reset -> bxn reads 3563 then 0.
- Apply bc0 when bxn=100 -> bxn=0 next cycle and bxn_err=1.
- bc0 at bxn=3563 -> bxn_err unchanged.
REQ-041 Delay change: change delay 3->5 -> tx_data=0 for 16 cycles, then correct frames with 7-cycle latency.
REQ-042 Test modes:
- tx_mode=2 -> tx_data[26:0] = 0x1, 0x2, ... 0x4000000, then 0x1.
- tx_mode=3 -> 0, 1, 2, ...
- Both with and without LCT_TX_PARITY_EN, checking bit 27 against REQ-036/037.
REQ-043 trig_stop=1 with hv=lv=1 -> both valid bits 0; wire and quality fields intact.
